dmem_access_unit: RTL and testbench

// Load/store unit between the core's MEM stage and the word-wide data port of the unified memory.

---
 rtl/dmem_access_unit.sv | 144 ++++++++++++++
 tb/tb_dmem_access_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Load/store unit between the MEM stage and a word-wide memory with registered reads.
// Sub-word stores are done as read-modify-write; bad requests are answered with resp_err.
module dmem_access_unit #(
  parameter int unsigned awidth = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] addr_d,
  input  logic [31:0] rdata,
  output logic        wen,
  output logic [31:0] wdata
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR, RESP} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  funct3_q;
  logic        wen_q;

  logic        accept, req_err, misaligned, bad_funct3, fault;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_value, merged;

  // Shifting by awidth==32 yields zero, which disables the range check.
  always_comb begin
    fault      = |(req_addr >> awidth);
    bad_funct3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                 (req_wen && req_funct3[2]);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err    = fault || bad_funct3 || misaligned;
    accept     = req_valid && (state == IDLE);
  end

  always_comb begin
    byte_lane = 8'h00;
    case (addr_q[1:0])
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = 8'h00;
    endcase
    half_lane = addr_q[1] ? rdata[31:16] : rdata[15:0];

    load_value = rdata;
    case (funct3_q)
      3'b000:  load_value = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_value = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_value = {24'h000000, byte_lane};
      3'b101:  load_value = {16'h0000, half_lane};
      default: load_value = rdata;
    endcase

    merged = rdata;
    if (funct3_q[0]) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                                state_next = RESP;
          else if (req_wen && req_funct3[1:0] == 2'b10) state_next = WR;
          else                                        state_next = RD_ISSUE;
        end
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT:  state_next = wen_q ? WR : RESP;
      WR:       state_next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  assign wen    = (state == WR) && !rst;
  assign addr_d = {addr_q[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Response fields are only written on the way into RESP so they hold between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      funct3_q   <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      wdata      <= '0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        wen_q    <= req_wen;
        wdata_q  <= req_wdata;
        if (req_err) begin
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end else if (req_wen && req_funct3[1:0] == 2'b10) begin
          wdata <= req_wdata;
        end
      end
      if (state == RD_WAIT) begin
        if (wen_q) begin
          wdata <= merged;
        end else begin
          resp_rdata <= load_value;
          resp_err   <= 1'b0;
        end
      end
      if (state == WR) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: a registered-read word memory plus a byte-level reference model,
// driven by directed scenarios and randomized load/store traffic.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] addr_d;
  logic [31:0] rdata;
  logic        wen;
  logic [31:0] wdata;

  logic        mem_clear;
  logic [31:0] mem [0:63];
  logic [7:0]  ref_mem [0:255];

  int          tests = 0;
  int          fails = 0;
  logic [31:0] obs_rdata;
  logic [31:0] obs_wdata;
  int          obs_wen_cyc;

  always #5 clk = ~clk;

  dmem_access_unit #(.awidth(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .addr_d     (addr_d),
    .rdata      (rdata),
    .wen        (wen),
    .wdata      (wdata)
  );

  // Attached memory: registered read of the presented word, whole-word writes.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (wen) begin
      mem[addr_d[7:2]] <= wdata;
    end
    rdata <= mem[addr_d[7:2]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int ref_size(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit ref_err(input bit w, input logic [2:0] f, input logic [31:0] a);
    if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b1;
    if (w && f >= 3'd4) return 1'b1;
    if ((a % ref_size(f)) != 0) return 1'b1;
    if (a >= 32'h0001_0000) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a);
    longint v = 0;
    int     n = ref_size(f);
    for (int i = 0; i < n; i++) v += longint'(ref_mem[(a + i) % 256]) << (8 * i);
    if (f < 3'd4 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  // Called on a negative edge with the unit idle; returns on the negedge one cycle after the response.
  task automatic applyStimulus(input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    bit          e;
    int          n, exp_lat, obs_lat, wen_cnt;
    logic [31:0] exp_rd;
    e       = ref_err(w, f, a);
    n       = ref_size(f);
    exp_rd  = (e || w) ? 32'h0 : ref_load(f, a);
    exp_lat = e ? 1 : (!w ? 3 : (n == 4 ? 2 : 4));
    checkOutput("ready", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_wen    = w;
    req_funct3 = f;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_wen    = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    obs_lat = 0;
    wen_cnt = 0;
    obs_wen_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (wen) begin
        wen_cnt++;
        obs_wen_cyc = c;
        obs_wdata   = wdata;
        checkOutput("wen_addr", addr_d, a & ~32'h3);
      end
      if (resp_valid) begin
        obs_lat   = c;
        obs_rdata = resp_rdata;
        checkOutput("resp_err", {31'd0, resp_err}, {31'd0, e});
        break;
      end
    end
    checkOutput("latency", obs_lat, exp_lat);
    checkOutput("resp_rdata", obs_rdata, exp_rd);
    checkOutput("wen_count", wen_cnt, (w && !e) ? 1 : 0);
    if (w && !e) checkOutput("wen_cycle", obs_wen_cyc, exp_lat - 1);
    @(negedge clk);
    checkOutput("resp_pulse", {31'd0, resp_valid}, 32'd0);
    if (w && !e) begin
      for (int i = 0; i < n; i++) ref_mem[(a + i) % 256] = d[8 * i +: 8];
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    bit          w;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] exp_word;

    rst        = 1'b1;
    mem_clear  = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    obs_rdata  = 32'h0;
    obs_wdata  = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
    checkOutput("rst_addr_d", addr_d, 32'd0);
    checkOutput("rst_wdata", wdata, 32'd0);
    checkOutput("rst_wen", {31'd0, wen}, 32'd0);
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
    rst       = 1'b0;
    mem_clear = 1'b0;
    @(negedge clk);

    for (int i = 16; i < 32; i++) applyStimulus(1'b1, 3'b010, 32'(i * 4), $urandom);

    applyStimulus(1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'b010, 32'h40, 32'h0);
    checkOutput("t1_lw", obs_rdata, 32'hDEADBEEF);

    applyStimulus(1'b1, 3'b010, 32'h40, 32'h80FF7F01);
    applyStimulus(1'b0, 3'b000, 32'h43, 32'h0);
    checkOutput("t2_lb", obs_rdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'b100, 32'h43, 32'h0);
    checkOutput("t2_lbu", obs_rdata, 32'h00000080);
    applyStimulus(1'b0, 3'b001, 32'h42, 32'h0);
    checkOutput("t2_lh", obs_rdata, 32'hFFFF80FF);

    applyStimulus(1'b1, 3'b010, 32'h40, 32'h11223344);
    applyStimulus(1'b1, 3'b000, 32'h41, 32'h000000AA);
    checkOutput("t3_wdata", obs_wdata, 32'h1122AA44);
    checkOutput("t3_wen_cycle", obs_wen_cyc, 3);

    applyStimulus(1'b1, 3'b010, 32'h44, 32'h12345678);
    checkOutput("t4_wen_cycle", obs_wen_cyc, 1);
    applyStimulus(1'b0, 3'b010, 32'h44, 32'h0);
    checkOutput("t4_readback", obs_rdata, 32'h12345678);

    applyStimulus(1'b0, 3'b010, 32'h42, 32'h0);
    applyStimulus(1'b1, 3'b001, 32'h43, 32'h5555);
    applyStimulus(1'b0, 3'b011, 32'h40, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h0001_0000, 32'h0);

    // sb interrupted by reset in its write cycle must leave memory and response untouched.
    applyStimulus(1'b1, 3'b010, 32'h40, 32'h11223344);
    req_valid  = 1'b1;
    req_wen    = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h41;
    req_wdata  = 32'h000000AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t6_in_wr", {31'd0, wen}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6_wen_rst", {31'd0, wen}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_ready", {31'd0, req_ready}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      checkOutput("t6_no_resp", {31'd0, resp_valid}, 32'd0);
      if (c < 3) @(negedge clk);
    end
    applyStimulus(1'b0, 3'b010, 32'h40, 32'h0);
    checkOutput("t6_mem", obs_rdata, 32'h11223344);

    for (int k = 0; k < 150; k++) begin
      w = 1'($urandom);
      f = 3'($urandom_range(0, 7));
      a = 32'h40 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) a = a | (32'h0001_0000 << $urandom_range(0, 15));
      applyStimulus(w, f, a, $urandom);
    end

    for (int i = 16; i < 32; i++) begin
      exp_word = {ref_mem[4 * i + 3], ref_mem[4 * i + 2], ref_mem[4 * i + 1], ref_mem[4 * i]};
      checkOutput("final_mem", mem[i], exp_word);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
